watch_timekeeper: RTL and testbench



---
 rtl/watch_pkg.sv | 12 +
 rtl/watch_mod_counter.sv | 40 ++++
 rtl/watch_timekeeper.sv | 141 ++++++++++++++
 tb/tb_watch_timekeeper.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared time-of-day field limits and widths for the watch datapath and display blocks.
package watch_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

endpackage

// File: rtl/watch_mod_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous clear and a same-edge carry on MAX->0.
module watch_mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         carry
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc && !dec) begin
            value_d = (value_q == W'(MAX)) ? '0 : value_q + 1'b1;
        end else if (dec && !inc) begin
            value_d = (value_q == '0) ? W'(MAX) : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    // Combinational so the next field can step on the very same edge.
    assign carry = inc && !dec && !clr && (value_q == W'(MAX));
    assign value = value_q;

endmodule

// File: rtl/watch_timekeeper.sv
// Time-of-day and stopwatch datapath: 1 Hz prescalers, carry chain, and edge-triggered set steps.
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int TICK_DIV = 32768,
    parameter int DIV_W    = $clog2(TICK_DIV)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_time,
    input  logic              inc_h,
    input  logic              dec_h,
    input  logic              inc_m,
    input  logic              dec_m,
    input  logic              run_stopwatch,
    input  logic              reset_stopwatch,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  sw_min,
    output logic [SEC_W-1:0]  sw_sec,
    output logic              tick_1hz,
    output logic              sw_wrap
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] tdiv_q, tdiv_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d;
    logic             inc_h_q, dec_h_q, inc_m_q, dec_m_q;
    logic             tick_q, sw_wrap_q;

    logic t_wrap, s_wrap;
    logic step_inc_h, step_dec_h, step_inc_m, step_dec_m, min_step;
    logic sec_carry, min_carry, hour_carry_unused;
    logic sw_sec_carry, sw_min_carry;

    assign t_wrap = run_time && (tdiv_q == DIV_LAST);
    assign s_wrap = !reset_stopwatch && run_stopwatch && (sdiv_q == DIV_LAST);

    // Steps only on a rising edge; history still tracks while running so a held
    // button does not fire when run_time drops.
    assign step_inc_h = !run_time && inc_h && !inc_h_q;
    assign step_dec_h = !run_time && dec_h && !dec_h_q;
    assign step_inc_m = !run_time && inc_m && !inc_m_q;
    assign step_dec_m = !run_time && dec_m && !dec_m_q;
    assign min_step   = step_inc_m ^ step_dec_m;

    always_comb begin
        tdiv_d = '0;
        if (run_time && !t_wrap) begin
            tdiv_d = tdiv_q + 1'b1;
        end
    end

    always_comb begin
        sdiv_d = sdiv_q;
        if (reset_stopwatch) begin
            sdiv_d = '0;
        end else if (run_stopwatch) begin
            sdiv_d = s_wrap ? '0 : sdiv_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tdiv_q    <= '0;
            sdiv_q    <= '0;
            inc_h_q   <= 1'b0;
            dec_h_q   <= 1'b0;
            inc_m_q   <= 1'b0;
            dec_m_q   <= 1'b0;
            tick_q    <= 1'b0;
            sw_wrap_q <= 1'b0;
        end else begin
            tdiv_q    <= tdiv_d;
            sdiv_q    <= sdiv_d;
            inc_h_q   <= inc_h;
            dec_h_q   <= dec_h;
            inc_m_q   <= inc_m;
            dec_m_q   <= dec_m;
            tick_q    <= t_wrap;
            sw_wrap_q <= sw_min_carry;
        end
    end

    watch_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_seconds (
        .clk   (clk),
        .reset (reset),
        .clr   (min_step),
        .inc   (t_wrap),
        .dec   (1'b0),
        .value (seconds),
        .carry (sec_carry)
    );

    watch_mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_minutes (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (sec_carry || step_inc_m),
        .dec   (step_dec_m),
        .value (minutes),
        .carry (min_carry)
    );

    // A manual minute wrap must not borrow into hours, so only running carries propagate.
    watch_mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hours (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   ((min_carry && run_time) || step_inc_h),
        .dec   (step_dec_h),
        .value (hours),
        .carry (hour_carry_unused)
    );

    watch_mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sw_sec (
        .clk   (clk),
        .reset (reset),
        .clr   (reset_stopwatch),
        .inc   (s_wrap),
        .dec   (1'b0),
        .value (sw_sec),
        .carry (sw_sec_carry)
    );

    watch_mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_sw_min (
        .clk   (clk),
        .reset (reset),
        .clr   (reset_stopwatch),
        .inc   (sw_sec_carry),
        .dec   (1'b0),
        .value (sw_min),
        .carry (sw_min_carry)
    );

    assign tick_1hz = tick_q;
    assign sw_wrap  = sw_wrap_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: directed scenarios plus random stimulus against a seconds-of-day model.
module tb_watch_timekeeper;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run_time = 1'b0;
    logic       inc_h = 1'b0, dec_h = 1'b0, inc_m = 1'b0, dec_m = 1'b0;
    logic       run_stopwatch = 1'b0, reset_stopwatch = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes, seconds, sw_min, sw_sec;
    logic       tick_1hz, sw_wrap;

    int errors = 0;
    int checks = 0;

    // Reference state: whole seconds of day / stopwatch, plus prescaler phases.
    int m_tod, m_sw, m_tdiv, m_sdiv;
    bit m_tick, m_wrap;
    bit p_ih, p_dh, p_im, p_dm;

    watch_timekeeper #(.TICK_DIV(N)) dut (
        .clk             (clk),
        .reset           (reset),
        .run_time        (run_time),
        .inc_h           (inc_h),
        .dec_h           (dec_h),
        .inc_m           (inc_m),
        .dec_m           (dec_m),
        .run_stopwatch   (run_stopwatch),
        .reset_stopwatch (reset_stopwatch),
        .hours           (hours),
        .minutes         (minutes),
        .seconds         (seconds),
        .sw_min          (sw_min),
        .sw_sec          (sw_sec),
        .tick_1hz        (tick_1hz),
        .sw_wrap         (sw_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tod = 0; m_sw = 0; m_tdiv = 0; m_sdiv = 0;
        m_tick = 0; m_wrap = 0;
        p_ih = 0; p_dh = 0; p_im = 0; p_dm = 0;
    endtask

    task automatic model_step();
        int h, m, s;
        bit ri_h, rd_h, ri_m, rd_m;
        if (!reset) begin
            model_reset();
            return;
        end
        m_tick = 0;
        if (run_time) begin
            if (m_tdiv == N - 1) begin
                m_tdiv = 0;
                m_tick = 1;
                m_tod  = (m_tod + 1) % 86400;
            end else begin
                m_tdiv++;
            end
        end else begin
            m_tdiv = 0;
            h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
            ri_h = inc_h && !p_ih; rd_h = dec_h && !p_dh;
            ri_m = inc_m && !p_im; rd_m = dec_m && !p_dm;
            if (ri_h != rd_h) h = ri_h ? (h + 1) % 24 : (h + 23) % 24;
            if (ri_m != rd_m) begin
                m = ri_m ? (m + 1) % 60 : (m + 59) % 60;
                s = 0;
            end
            m_tod = h * 3600 + m * 60 + s;
        end
        p_ih = inc_h; p_dh = dec_h; p_im = inc_m; p_dm = dec_m;
        m_wrap = 0;
        if (reset_stopwatch) begin
            m_sdiv = 0;
            m_sw   = 0;
        end else if (run_stopwatch) begin
            if (m_sdiv == N - 1) begin
                m_sdiv = 0;
                if (m_sw == 3599) m_wrap = 1;
                m_sw = (m_sw + 1) % 3600;
            end else begin
                m_sdiv++;
            end
        end
    endtask

    task automatic compare_all();
        chk("hours",    int'(hours),    m_tod / 3600);
        chk("minutes",  int'(minutes),  (m_tod / 60) % 60);
        chk("seconds",  int'(seconds),  m_tod % 60);
        chk("sw_min",   int'(sw_min),   m_sw / 60);
        chk("sw_sec",   int'(sw_sec),   m_sw % 60);
        chk("tick_1hz", int'(tick_1hz), int'(m_tick));
        chk("sw_wrap",  int'(sw_wrap),  int'(m_wrap));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press(input int b);
        case (b)
            0: inc_h = 1'b1;
            1: dec_h = 1'b1;
            2: inc_m = 1'b1;
            default: dec_m = 1'b1;
        endcase
        cyc();
        inc_h = 1'b0; dec_h = 1'b0; inc_m = 1'b0; dec_m = 1'b0;
        cyc();
    endtask

    task automatic async_reset_now();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
    endtask

    initial begin
        model_reset();
        // Reset and first tick
        #2;
        async_reset_now();
        cycles(3);
        reset = 1'b1;
        run_time = 1'b1;
        cycles(3);
        chk("no_early_tick", int'(tick_1hz), 0);
        cyc();
        chk("first_tick", int'(tick_1hz), 1);
        chk("first_sec", int'(seconds), 1);

        // Adjust
        run_time = 1'b0;
        cyc();
        dec_h = 1'b1;
        cycles(10);
        dec_h = 1'b0;
        cyc();
        chk("dec_h_wrap_once", int'(hours), 23);
        press(3);
        chk("dec_m_wrap", int'(minutes), 59);
        press(2);
        chk("inc_m_wrap_min", int'(minutes), 0);
        chk("inc_m_no_carry", int'(hours), 23);
        chk("inc_m_clr_sec", int'(seconds), 0);
        inc_m = 1'b1; dec_m = 1'b1;
        cyc();
        inc_m = 1'b0; dec_m = 1'b0;
        cyc();
        chk("inc_dec_same", int'(minutes), 0);
        run_time = 1'b1;
        inc_h = 1'b1;
        cyc();
        run_time = 1'b0;
        cycles(2);
        inc_h = 1'b0;
        cyc();
        chk("held_across_run", int'(hours), 23);

        // Carry chain to midnight
        press(3);
        run_time = 1'b1;
        cycles(59 * N);
        chk("pre_mid_h", int'(hours), 23);
        chk("pre_mid_m", int'(minutes), 59);
        chk("pre_mid_s", int'(seconds), 59);
        cycles(N);
        chk("mid_h", int'(hours), 0);
        chk("mid_m", int'(minutes), 0);
        chk("mid_s", int'(seconds), 0);

        // Stopwatch
        run_stopwatch = 1'b1;
        cycles(8);
        chk("sw_run8", int'(sw_sec), 2);
        run_stopwatch = 1'b0;
        cycles(10);
        chk("sw_pause", int'(sw_sec), 2);
        reset_stopwatch = 1'b1;
        cyc();
        reset_stopwatch = 1'b0;
        chk("sw_clr_s", int'(sw_sec), 0);
        chk("sw_clr_m", int'(sw_min), 0);
        run_stopwatch = 1'b1;
        cycles(3599 * N);
        chk("sw_5959_m", int'(sw_min), 59);
        chk("sw_5959_s", int'(sw_sec), 59);
        cycles(N);
        chk("sw_wrap_pulse", int'(sw_wrap), 1);
        chk("sw_wrap_zero", int'(sw_min) * 60 + int'(sw_sec), 0);
        cyc();
        chk("sw_wrap_one_cycle", int'(sw_wrap), 0);

        // Clear wins over a wrap edge
        cycles(3599 * N + N - 2);
        reset_stopwatch = 1'b1;
        cyc();
        chk("prio_counts", int'(sw_min) * 60 + int'(sw_sec), 0);
        reset_stopwatch = 1'b0;
        cyc();
        chk("prio_no_wrap", int'(sw_wrap), 0);
        run_stopwatch = 1'b0;

        // Async reset mid-count at 05:30:12
        run_time = 1'b0;
        for (int k = 0; k < 24 && (m_tod / 3600) != 5; k++) press(0);
        for (int k = 0; k < 60 && ((m_tod / 60) % 60) != 30; k++) press(2);
        run_time = 1'b1;
        cycles(12 * N);
        run_time = 1'b0;
        reset_stopwatch = 1'b1;
        cyc();
        reset_stopwatch = 1'b0;
        run_stopwatch = 1'b1;
        cycles(2);
        run_stopwatch = 1'b0;
        chk("pre_rst_h", int'(hours), 5);
        chk("pre_rst_m", int'(minutes), 30);
        chk("pre_rst_s", int'(seconds), 12);
        #2;
        async_reset_now();
        chk("async_h", int'(hours), 0);
        chk("async_s", int'(seconds), 0);
        cyc();
        reset = 1'b1;

        // Random stimulus
        for (int i = 0; i < 1500; i++) begin
            run_time        = ($urandom_range(0, 3) != 0);
            inc_h           = ($urandom_range(0, 3) == 0);
            dec_h           = ($urandom_range(0, 5) == 0);
            inc_m           = ($urandom_range(0, 3) == 0);
            dec_m           = ($urandom_range(0, 5) == 0);
            run_stopwatch   = ($urandom_range(0, 3) != 0);
            reset_stopwatch = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 300) == 0) begin
                #2;
                async_reset_now();
                cyc();
                reset = 1'b1;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
